signed_addsub_seq: RTL

SIGNED_ADDSUB_SEQ -- requirements
Module: signed_addsub_seq

---
 rtl/signed_addsub_pkg.sv | 34 +++
 rtl/signed_addsub_core.sv | 51 +++++
 rtl/signed_addsub_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/signed_addsub_pkg.sv
//==============================================================================
// Module   : signed_addsub_pkg
// Purpose  : Shared types for the signed add/subtract sequencer: operation
//            codes and FSM state names.
// Contents : op_t    - OP_ADD (A+B), OP_SUB (A-B), OP_ACC_ADD (ACC+A),
//                      OP_ACC_SUB (ACC-A)
//            state_t - IDLE (no result held), HOLD (result held)
//            op_uses_acc() - true for the two accumulator operations
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package signed_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The accumulator operations are exactly the codes with the top bit set.
    function automatic logic op_uses_acc(input logic [1:0] op_code);
        return (op_code == OP_ACC_ADD) || (op_code == OP_ACC_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/signed_addsub_core.sv
//==============================================================================
// Module   : signed_addsub_core
// Purpose  : Combinational two's-complement add/subtract with overflow
//            detection. Optional saturation when SIGNED_ADDSUB_SAT_EN is
//            defined; otherwise the result wraps around.
// Ports    : i_opa  [WIDTH]  signed first operand
//            i_opb  [WIDTH]  signed second operand
//            i_sub  [1]      1: i_opa - i_opb, 0: i_opa + i_opb
//            o_res  [WIDTH]  signed result (wrapped or saturated)
//            o_ovf  [1]      true result does not fit in WIDTH bits
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module signed_addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_res,
    output logic             o_ovf
);

    logic [WIDTH:0] w_ext_a;
    logic [WIDTH:0] w_ext_b;
    logic [WIDTH:0] w_sum;

    // One extra sign bit makes the intermediate exact for any +/- of two
    // WIDTH-bit signed values.
    assign w_ext_a = {i_opa[WIDTH-1], i_opa};
    assign w_ext_b = {i_opb[WIDTH-1], i_opb};
    assign w_sum   = i_sub ? (w_ext_a - w_ext_b) : (w_ext_a + w_ext_b);

    // Out of range exactly when the two top bits of the exact value disagree.
    assign o_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

`ifdef SIGNED_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // The extra sign bit gives the true sign of an overflowing result.
    assign o_res = !o_ovf     ? w_sum[WIDTH-1:0] :
                   w_sum[WIDTH] ? c_SAT_MIN : c_SAT_MAX;
`else
    assign o_res = w_sum[WIDTH-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/signed_addsub_seq.sv
//==============================================================================
// Module   : signed_addsub_seq
// Purpose  : Sequenced signed add/subtract unit with accumulator, one-cycle
//            registered result behind a valid/ready handshake, sticky
//            overflow flag and accepted-operation counter.
// Config   : define SIGNED_ADDSUB_SAT_EN to saturate overflowing results
//            (res and acc); default build wraps around.
// Ports    : clk, rst      clock, asynchronous active-high reset
//            in_a, in_b    [WIDTH] signed operands
//            op            [2]     00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A
//            in_valid/in_ready     request handshake
//            clr           synchronous clear of acc and ovf_sticky
//            res, res_ovf  registered result and its overflow flag
//            out_valid/out_ready   result handshake
//            acc           [WIDTH] accumulator
//            ovf_sticky    any accepted overflow since clr/rst
//            op_cnt        [CNT_WIDTH] accepted requests, wrapping
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module signed_addsub_seq
    import signed_addsub_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           op,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clr,
    output logic [WIDTH-1:0]     res,
    output logic                 res_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     acc,
    output logic                 ovf_sticky,
    output logic [CNT_WIDTH-1:0] op_cnt
);

    localparam logic [0:0] c_ST_IDLE = IDLE;
    localparam logic [0:0] c_ST_HOLD = HOLD;

    logic [0:0]           r_state;
    logic [WIDTH-1:0]     r_res;
    logic                 r_res_ovf;
    logic [WIDTH-1:0]     r_acc;
    logic                 r_ovf_sticky;
    logic [CNT_WIDTH-1:0] r_op_cnt;

    logic                 w_accept;
    logic                 w_acc_op;
    logic [WIDTH-1:0]     w_acc_base;
    logic [WIDTH-1:0]     w_opa;
    logic [WIDTH-1:0]     w_opb;
    logic [WIDTH-1:0]     w_res;
    logic                 w_ovf;

    // A held result that is being drained this cycle frees the register,
    // so a new request can be taken in the same cycle.
    assign in_ready = (r_state == c_ST_IDLE) || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_acc_op = op_uses_acc(op);

    // A clear arriving with an accumulator op makes that op start from zero.
    assign w_acc_base = clr ? '0 : r_acc;
    assign w_opa      = w_acc_op ? w_acc_base : in_a;
    assign w_opb      = w_acc_op ? in_a       : in_b;

    signed_addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_opa (w_opa),
        .i_opb (w_opb),
        .i_sub (op[0]),
        .o_res (w_res),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else if (w_accept) begin
            r_state <= c_ST_HOLD;
        end else if (out_ready) begin
            r_state <= c_ST_IDLE;
        end
    end

    // Result register only changes on accept, so it is stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res     <= '0;
            r_res_ovf <= 1'b0;
        end else if (w_accept) begin
            r_res     <= w_res;
            r_res_ovf <= w_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept && w_acc_op) begin
            r_acc <= w_res;
        end else if (clr) begin
            r_acc <= '0;
        end
    end

    // On clr the previous sticky value is dropped; only this cycle's
    // accepted overflow (if any) survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (clr) begin
            r_ovf_sticky <= w_accept && w_ovf;
        end else if (w_accept && w_ovf) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_cnt <= '0;
        end else if (w_accept) begin
            r_op_cnt <= r_op_cnt + CNT_WIDTH'(1);
        end
    end

    assign res        = r_res;
    assign res_ovf    = r_res_ovf;
    assign out_valid  = (r_state == c_ST_HOLD);
    assign acc        = r_acc;
    assign ovf_sticky = r_ovf_sticky;
    assign op_cnt     = r_op_cnt;

endmodule

`default_nettype wire
